// File: rtl/alu_pipe.sv
//==============================================================================
// Module   : alu_pipe
// Brief    : Pipelined valid/ready ALU with in-order results, flags and tags.
//            Define ALU_MUL_EN to build the iterative shift-add multiplier.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_pipe #(
   parameter int WORD_SIZE   = 32,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] in1,
   input  logic [WORD_SIZE-1:0] in2,
   input  logic [4:0]           func,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic [3:0]           flags,
   output logic                 illegal
);

   localparam int         c_sh_w = $clog2(WORD_SIZE);
   localparam int         c_msb  = WORD_SIZE - 1;

   localparam logic [4:0] c_add  = 5'd0;
   localparam logic [4:0] c_sub  = 5'd1;
   localparam logic [4:0] c_and  = 5'd2;
   localparam logic [4:0] c_or   = 5'd3;
   localparam logic [4:0] c_xor  = 5'd4;
   localparam logic [4:0] c_nand = 5'd5;
   localparam logic [4:0] c_nor  = 5'd6;
   localparam logic [4:0] c_xnor = 5'd7;
   localparam logic [4:0] c_mvhi = 5'd8;
   localparam logic [4:0] c_f    = 5'd9;
   localparam logic [4:0] c_eq   = 5'd10;
   localparam logic [4:0] c_lt   = 5'd11;
   localparam logic [4:0] c_ltu  = 5'd12;
   localparam logic [4:0] c_sll  = 5'd13;
   localparam logic [4:0] c_srl  = 5'd14;
   localparam logic [4:0] c_sra  = 5'd15;
   localparam logic [4:0] c_mul  = 5'd16;

   typedef struct packed {
      logic [WORD_SIZE-1:0] res;
      logic [TAG_WIDTH-1:0] tag;
      logic [3:0]           flg;
      logic                 ill;
   } beat_t;

   // ---------------------------------------------------------------- ALU ---
   logic [WORD_SIZE:0]   w_sum;
   logic [WORD_SIZE:0]   w_dif;
   logic [c_sh_w-1:0]    w_sh;
   logic [WORD_SIZE-1:0] w_res;
   logic                 w_c;
   logic                 w_v;
   logic                 w_ill;
   beat_t                w_new;

   assign w_sum = {1'b0, in1} + {1'b0, in2};
   // carry out of A + ~B + 1 is the "no borrow" bit for SUB
   assign w_dif = {1'b0, in1} + {1'b0, ~in2} + (WORD_SIZE+1)'(1);
   assign w_sh  = in2[c_sh_w-1:0];

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_ill = 1'b0;
      case (func)
         c_add: begin
            w_res = w_sum[WORD_SIZE-1:0];
            w_c   = w_sum[WORD_SIZE];
            w_v   = (in1[c_msb] == in2[c_msb]) && (w_sum[c_msb] != in1[c_msb]);
         end
         c_sub: begin
            w_res = w_dif[WORD_SIZE-1:0];
            w_c   = w_dif[WORD_SIZE];
            w_v   = (in1[c_msb] != in2[c_msb]) && (w_dif[c_msb] != in1[c_msb]);
         end
         c_and:  w_res = in1 & in2;
         c_or:   w_res = in1 | in2;
         c_xor:  w_res = in1 ^ in2;
         c_nand: w_res = ~(in1 & in2);
         c_nor:  w_res = ~(in1 | in2);
         c_xnor: w_res = ~(in1 ^ in2);
         c_mvhi: w_res = in2 << (WORD_SIZE / 2);
         c_f:    w_res = '0;
         c_eq:   w_res = {{(WORD_SIZE-1){1'b0}}, (in1 == in2)};
         c_lt:   w_res = {{(WORD_SIZE-1){1'b0}}, ($signed(in1) < $signed(in2))};
         c_ltu:  w_res = {{(WORD_SIZE-1){1'b0}}, (in1 < in2)};
         c_sll:  w_res = in1 << w_sh;
         c_srl:  w_res = in1 >> w_sh;
         c_sra:  w_res = $signed(in1) >>> w_sh;
`ifdef ALU_MUL_EN
         c_mul:  w_res = '0;
`else
         c_mul:  w_ill = 1'b1;
`endif
         default: w_ill = 1'b1;
      endcase
   end

   always_comb begin
      w_new     = '0;
      w_new.res = w_res;
      w_new.tag = in_tag;
      w_new.ill = w_ill;
      w_new.flg = w_ill ? 4'b0000 : {w_c, w_v, w_res[c_msb], (w_res == '0)};
   end

   // ----------------------------------------------------------- pipeline ---
   logic [PIPE_STAGES-1:0] r_vld;
   beat_t                  r_pl [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] w_ld;
   logic                   w_hole;
   logic                   w_acc;
   logic                   w_acc_alu;
   logic                   w_mul_load;
   beat_t                  w_mul_pl;

   // A stage loads when it, or any stage after it, is empty, or the output drains
   always_comb begin
      w_hole = out_ready;
      w_ld   = '0;
      for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
         w_hole  = w_hole | ~r_vld[i];
         w_ld[i] = w_hole;
      end
   end

   assign w_acc = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            r_pl[i] <= '0;
         end
      end else begin
         if (w_ld[0]) begin
            r_vld[0] <= w_acc_alu;
            if (w_acc_alu) begin
               r_pl[0] <= w_new;
            end
         end
         for (int i = 1; i < PIPE_STAGES; i++) begin
            if (w_ld[i]) begin
               r_vld[i] <= r_vld[i-1];
               if (r_vld[i-1]) begin
                  r_pl[i] <= r_pl[i-1];
               end
            end
         end
         // The multiplier only finishes once the pipe is drained, so this cannot clobber data
         if (w_mul_load) begin
            r_vld[PIPE_STAGES-1] <= 1'b1;
            r_pl[PIPE_STAGES-1]  <= w_mul_pl;
         end
      end
   end

   assign out_valid = r_vld[PIPE_STAGES-1];
   assign out       = r_pl[PIPE_STAGES-1].res;
   assign out_tag   = r_pl[PIPE_STAGES-1].tag;
   assign flags     = r_pl[PIPE_STAGES-1].flg;
   assign illegal   = r_pl[PIPE_STAGES-1].ill;

   // --------------------------------------------------------- multiplier ---
`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_MUL   = 2'd2,
      S_DONE  = 2'd3
   } mul_state_t;

   localparam int               c_cnt_w    = $clog2(WORD_SIZE);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WORD_SIZE - 1);

   mul_state_t           r_state;
   mul_state_t           w_state_nxt;
   logic [WORD_SIZE-1:0] r_ma;
   logic [WORD_SIZE-1:0] r_mb;
   logic [WORD_SIZE-1:0] r_macc;
   logic [WORD_SIZE-1:0] w_macc_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [TAG_WIDTH-1:0] r_mtag;
   logic                 w_is_mul;
   logic                 w_mul_start;
   logic                 w_cnt_last;

   assign w_is_mul    = (func == c_mul);
   assign in_ready    = w_ld[0] && (r_state == S_IDLE);
   assign w_acc_alu   = w_acc && !w_is_mul;
   assign w_mul_start = w_acc && w_is_mul;
   assign w_cnt_last  = (r_cnt == c_cnt_last);
   assign w_macc_nxt  = r_macc + (r_mb[0] ? r_ma : '0);
   assign w_mul_load  = (r_state == S_MUL) && w_cnt_last;

   always_comb begin
      w_mul_pl     = '0;
      w_mul_pl.res = w_macc_nxt;
      w_mul_pl.tag = r_mtag;
      w_mul_pl.flg = {2'b00, w_macc_nxt[c_msb], (w_macc_nxt == '0)};
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_mul_start)     w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_vld == '0)     w_state_nxt = S_MUL;
         S_MUL:   if (w_cnt_last)      w_state_nxt = S_DONE;
         S_DONE:  if (out_ready)       w_state_nxt = S_IDLE;
         default:                      w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ma    <= '0;
         r_mb    <= '0;
         r_macc  <= '0;
         r_cnt   <= '0;
         r_mtag  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_mul_start) begin
            r_ma   <= in1;
            r_mb   <= in2;
            r_macc <= '0;
            r_cnt  <= '0;
            r_mtag <= in_tag;
         end else if (r_state == S_MUL) begin
            r_macc <= w_macc_nxt;
            r_ma   <= r_ma << 1;
            r_mb   <= r_mb >> 1;
            r_cnt  <= r_cnt + 1'b1;
         end
      end
   end
`else
   assign in_ready   = w_ld[0];
   assign w_acc_alu  = w_acc;
   assign w_mul_load = 1'b0;
   assign w_mul_pl   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
//==============================================================================
// Module   : tb_alu_pipe
// Brief    : Self-checking bench for alu_pipe against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_pipe;
   localparam int W = 32;
   localparam int S = 2;
   localparam int T = 4;

   localparam logic [4:0] F_ADD = 5'd0,  F_SUB = 5'd1,  F_AND = 5'd2,  F_OR   = 5'd3;
   localparam logic [4:0] F_XOR = 5'd4,  F_NAND = 5'd5, F_NOR = 5'd6,  F_XNOR = 5'd7;
   localparam logic [4:0] F_MVHI = 5'd8, F_F = 5'd9,    F_EQ = 5'd10,  F_LT   = 5'd11;
   localparam logic [4:0] F_LTU = 5'd12, F_SLL = 5'd13, F_SRL = 5'd14, F_SRA  = 5'd15;
   localparam logic [4:0] F_MUL = 5'd16;

   typedef struct packed {
      logic [4:0]   func;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [T-1:0] tag;
   } op_t;

   typedef struct {
      logic [W-1:0] res;
      logic [T-1:0] tag;
      logic [3:0]   flg;
      logic         ill;
      int           cyc;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in1 = '0;
   logic [W-1:0] in2 = '0;
   logic [4:0]   func = '0;
   logic [T-1:0] in_tag = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out;
   logic [T-1:0] out_tag;
   logic [3:0]   flags;
   logic         illegal;

   op_t   send_q[$];
   beat_t exp_q[$];
   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WORD_SIZE(W), .PIPE_STAGES(S), .TAG_WIDTH(T)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .func(func), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .out_tag(out_tag), .flags(flags), .illegal(illegal)
   );

   // Reference model: results straight from the arithmetic definitions
   function automatic beat_t model(input op_t op);
      beat_t           m;
      longint unsigned ua, ub;
      longint          sa, sb;
      logic [W-1:0]    r;
      logic            c, v, ill;
      ua = 64'(op.a);
      ub = 64'(op.b);
      sa = longint'($signed(op.a));
      sb = longint'($signed(op.b));
      r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
      case (op.func)
         F_ADD: begin r = op.a + op.b; c = ((ua + ub) >> 32) != 0; v = (sa + sb) != longint'($signed(r)); end
         F_SUB: begin r = op.a - op.b; c = (ua >= ub); v = (sa - sb) != longint'($signed(r)); end
         F_AND:  r = op.a & op.b;
         F_OR:   r = op.a | op.b;
         F_XOR:  r = op.a ^ op.b;
         F_NAND: r = ~(op.a & op.b);
         F_NOR:  r = ~(op.a | op.b);
         F_XNOR: r = ~(op.a ^ op.b);
         F_MVHI: r = op.b << (W / 2);
         F_F:    r = '0;
         F_EQ:   r = (op.a == op.b) ? 32'd1 : 32'd0;
         F_LT:   r = (sa < sb) ? 32'd1 : 32'd0;
         F_LTU:  r = (ua < ub) ? 32'd1 : 32'd0;
         F_SLL:  r = op.a << op.b[4:0];
         F_SRL:  r = op.a >> op.b[4:0];
         F_SRA:  r = 32'(sa >>> op.b[4:0]);
`ifdef ALU_MUL_EN
         F_MUL:  r = 32'(ua * ub);
`else
         F_MUL:  ill = 1'b1;
`endif
         default: ill = 1'b1;
      endcase
      m.res = r;
      m.tag = op.tag;
      m.ill = ill;
      m.flg = ill ? 4'b0000 : {c, v, r[W-1], (r == '0)};
      m.cyc = 0;
      return m;
   endfunction

   // One clock: drive at the falling edge, observe what the next rising edge will see
   task automatic tick(input logic ordy, input logic gap, output logic acc, output logic rdy,
                       output logic vld, output logic got, output beat_t obs);
      beat_t e;
      @(negedge clk);
      out_ready = ordy;
      if (send_q.size() > 0 && !gap) begin
         in_valid = 1'b1;
         func     = send_q[0].func;
         in1      = send_q[0].a;
         in2      = send_q[0].b;
         in_tag   = send_q[0].tag;
      end else begin
         in_valid = 1'b0;
      end
      #1;
      rdy = in_ready;
      acc = in_valid && in_ready;
      vld = out_valid;
      got = out_valid && out_ready;
      obs.res = out; obs.tag = out_tag; obs.flg = flags; obs.ill = illegal; obs.cyc = cyc;
      if (acc) begin
         e = model(send_q[0]);
         e.cyc = cyc;
         exp_q.push_back(e);
         void'(send_q.pop_front());
      end
      cyc++;
   endtask

   task automatic test_reset();
      logic acc, rdy, vld, got;
      beat_t obs;
      int stale;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out !== '0 || out_tag !== '0 || flags !== '0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_values: got vld=%b out=%h tag=%h flags=%b ill=%b rdy=%b, required 0/0/0/0/0/rdy=1",
                  out_valid, out, out_tag, flags, illegal, in_ready);
      end
      send_q.push_back('{F_ADD, 32'd10, 32'd20, 4'd1});
      send_q.push_back('{F_SUB, 32'd30, 32'd5, 4'd2});
      repeat (3) tick(1'b0, 1'b0, acc, rdy, vld, got, obs);
      n_cmp++;
      if (vld !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_pre_inflight: got out_valid=%b, required 1", vld);
      end
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out !== '0 || out_tag !== '0) begin
         n_bad++;
         $display("FAIL reset_async: got vld=%b out=%h tag=%h, required 0/0/0", out_valid, out, out_tag);
      end
      send_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b0, acc, rdy, vld, got, obs);
         if (vld || !rdy) stale++;
      end
      n_cmp++;
      if (stale != 0) begin
         n_bad++;
         $display("FAIL reset_no_stale: got %0d cycles with stale output or in_ready low, required 0", stale);
      end
   endtask

   typedef struct {
      logic [4:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  fl;
   } dir_t;

   task automatic test_directed();
      dir_t tbl[12] = '{
         '{F_ADD,  32'd3,          32'd5, 32'd8,          4'b0000},
         '{F_SUB,  32'd3,          32'd5, 32'hFFFF_FFFE,  4'b0010},
         '{F_EQ,   32'd3,          32'd3, 32'd1,          4'b0000},
         '{F_MVHI, 32'd0,          32'd5, 32'h0005_0000,  4'b0000},
         '{F_F,    32'd1,          32'd2, 32'd0,          4'b0001},
         '{F_ADD,  32'h7FFF_FFFF,  32'd1, 32'h8000_0000,  4'b0110},
         '{F_ADD,  32'hFFFF_FFFF,  32'd1, 32'd0,          4'b1001},
         '{F_SRA,  32'h8000_0000,  32'd4, 32'hF800_0000,  4'b0010},
         '{F_SUB,  32'd5,          32'd5, 32'd0,          4'b1001},
         '{F_LT,   32'hFFFF_FFFF,  32'd1, 32'd1,          4'b0000},
         '{F_LTU,  32'hFFFF_FFFF,  32'd1, 32'd0,          4'b0001},
         '{F_SLL,  32'd1,          32'd33, 32'd2,         4'b0000}
      };
      logic acc, rdy, vld, got;
      beat_t obs, e;
      for (int i = 0; i < 12; i++) begin
         send_q.push_back('{tbl[i].f, tbl[i].a, tbl[i].b, T'(i)});
         got = 1'b0;
         for (int k = 0; k < 20 && !got; k++) tick(1'b1, 1'b0, acc, rdy, vld, got, obs);
         n_cmp++;
         if (!got || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL directed_timeout[%0d]: got no result, required out=%h", i, tbl[i].r);
            send_q.delete();
            exp_q.delete();
         end else begin
            e = exp_q.pop_front();
            if (obs.res !== tbl[i].r || obs.flg !== tbl[i].fl || obs.ill !== 1'b0 || obs.tag !== T'(i)) begin
               n_bad++;
               $display("FAIL directed[%0d]: got out=%h flags=%b ill=%b tag=%0d, required out=%h flags=%b ill=0 tag=%0d",
                        i, obs.res, obs.flg, obs.ill, obs.tag, tbl[i].r, tbl[i].fl, i);
            end
            n_cmp++;
            if (obs.cyc - e.cyc != S) begin
               n_bad++;
               $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, obs.cyc - e.cyc, S);
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic acc, rdy, vld, got;
      beat_t obs;
      int n;
      send_q.push_back('{5'h1F, $urandom, $urandom, 4'd9});
      send_q.push_back('{F_ADD, 32'd1, 32'd2, 4'd10});
      n = 0;
      for (int k = 0; k < 30 && n < 2; k++) begin
         tick(1'b1, 1'b0, acc, rdy, vld, got, obs);
         if (got) begin
            n_cmp++;
            if (n == 0 && (obs.res !== '0 || obs.flg !== 4'b0000 || obs.ill !== 1'b1 || obs.tag !== 4'd9)) begin
               n_bad++;
               $display("FAIL illegal_op: got out=%h flags=%b ill=%b tag=%0d, required 0/0000/1/9", obs.res, obs.flg, obs.ill, obs.tag);
            end
            if (n == 1 && (obs.res !== 32'd3 || obs.flg !== 4'b0000 || obs.ill !== 1'b0 || obs.tag !== 4'd10)) begin
               n_bad++;
               $display("FAIL illegal_next: got out=%h flags=%b ill=%b tag=%0d, required 3/0000/0/10", obs.res, obs.flg, obs.ill, obs.tag);
            end
            n++;
         end
      end
      n_cmp++;
      if (n != 2) begin
         n_bad++;
         $display("FAIL illegal_count: got %0d results, required 2", n);
      end
      exp_q.delete();
      send_q.delete();
   endtask

   task automatic test_back_to_back();
      logic acc, rdy, vld, got, prev_stall;
      beat_t obs, prev, e;
      int k, next_tag;
      for (int i = 0; i < 8; i++) send_q.push_back('{5'($urandom_range(0, 15)), $urandom, $urandom, T'(i)});
      prev_stall = 1'b0;
      prev = '{default: '0};
      next_tag = 0;
      k = 0;
      while ((send_q.size() > 0 || exp_q.size() > 0) && k < 200) begin
         tick(!(k >= 3 && k <= 6), 1'b0, acc, rdy, vld, got, obs);
         if (!rdy && in_valid) begin
            n_cmp++;
            if (exp_q.size() < S) begin
               n_bad++;
               $display("FAIL bp_ready_early: in_ready low with %0d ops held, required >= %0d", exp_q.size(), S);
            end
         end
         if (prev_stall) begin
            n_cmp++;
            if (!vld || obs.res !== prev.res || obs.tag !== prev.tag || obs.flg !== prev.flg) begin
               n_bad++;
               $display("FAIL bp_stable: got vld=%b out=%h tag=%0d, required vld=1 out=%h tag=%0d",
                        vld, obs.res, obs.tag, prev.res, prev.tag);
            end
         end
         prev_stall = vld && !got;
         prev = obs;
         if (got) begin
            n_cmp++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{default: '0};
            if (obs.tag !== T'(next_tag) || obs.res !== e.res || obs.flg !== e.flg || obs.ill !== e.ill) begin
               n_bad++;
               $display("FAIL bp_order: got tag=%0d out=%h flags=%b, required tag=%0d out=%h flags=%b",
                        obs.tag, obs.res, obs.flg, next_tag, e.res, e.flg);
            end
            next_tag++;
         end
         k++;
      end
      n_cmp++;
      if (next_tag != 8) begin
         n_bad++;
         $display("FAIL bp_count: got %0d results, required 8", next_tag);
      end
      send_q.delete();
      exp_q.delete();
   endtask

   task automatic test_mul();
      logic acc, rdy, vld, got;
      beat_t obs, e;
      int n;
      logic [T-1:0] tags[3] = '{4'd1, 4'd2, 4'd3};
      send_q.push_back('{F_ADD, 32'd1, 32'd2, 4'd1});
      send_q.push_back('{F_MUL, 32'd7, 32'd6, 4'd2});
      send_q.push_back('{F_ADD, 32'd10, 32'd20, 4'd3});
      n = 0;
      for (int k = 0; k < 200 && n < 3; k++) begin
         tick(1'b1, 1'b0, acc, rdy, vld, got, obs);
         if (got) begin
            n_cmp++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{default: '0};
            if (obs.tag !== tags[n] || obs.res !== e.res || obs.ill !== e.ill || obs.flg !== e.flg) begin
               n_bad++;
               $display("FAIL mul_order[%0d]: got tag=%0d out=%h ill=%b, required tag=%0d out=%h ill=%b",
                        n, obs.tag, obs.res, obs.ill, tags[n], e.res, e.ill);
            end
`ifdef ALU_MUL_EN
            if (n == 1) begin
               n_cmp++;
               if (obs.res !== 32'd42) begin
                  n_bad++;
                  $display("FAIL mul_value: got %0d, required 42", obs.res);
               end
            end
`endif
            n++;
         end
      end
      n_cmp++;
      if (n != 3) begin
         n_bad++;
         $display("FAIL mul_count: got %0d results, required 3", n);
      end
      send_q.delete();
      exp_q.delete();
      // lone MUL into an empty pipe: latency and value
      send_q.push_back('{F_MUL, 32'hFFFF_FFFF, 32'd3, 4'd5});
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) tick(1'b1, 1'b0, acc, rdy, vld, got, obs);
      n_cmp++;
      if (!got || exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL mul_timeout: got no result, required one");
      end else begin
         e = exp_q.pop_front();
`ifdef ALU_MUL_EN
         if (obs.res !== 32'hFFFF_FFFD || obs.flg !== 4'b0010 || obs.ill !== 1'b0 || obs.cyc - e.cyc != W + 2) begin
            n_bad++;
            $display("FAIL mul_lone: got out=%h flags=%b ill=%b lat=%0d, required FFFFFFFD/0010/0/%0d",
                     obs.res, obs.flg, obs.ill, obs.cyc - e.cyc, W + 2);
         end
`else
         if (obs.res !== '0 || obs.flg !== 4'b0000 || obs.ill !== 1'b1 || obs.cyc - e.cyc != S) begin
            n_bad++;
            $display("FAIL mul_lone: got out=%h flags=%b ill=%b lat=%0d, required 0/0000/1/%0d",
                     obs.res, obs.flg, obs.ill, obs.cyc - e.cyc, S);
         end
`endif
      end
      send_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      logic acc, rdy, vld, got;
      beat_t obs, e;
      int k, n_got, n_err;
      logic [4:0] f;
      for (int i = 0; i < 300; i++) begin
         f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
         send_q.push_back('{f, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, T'(i)});
      end
      k = 0;
      n_got = 0;
      n_err = 0;
      while ((send_q.size() > 0 || exp_q.size() > 0) && k < 30000) begin
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, acc, rdy, vld, got, obs);
         if (got) begin
            n_cmp++;
            n_got++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL rand_extra: got tag=%0d out=%h, required no output", obs.tag, obs.res);
            end else begin
               e = exp_q.pop_front();
               if (obs.res !== e.res || obs.tag !== e.tag || obs.flg !== e.flg || obs.ill !== e.ill) begin
                  n_bad++;
                  if (n_err < 10)
                     $display("FAIL rand_result: got out=%h tag=%0d flags=%b ill=%b, required out=%h tag=%0d flags=%b ill=%b",
                              obs.res, obs.tag, obs.flg, obs.ill, e.res, e.tag, e.flg, e.ill);
                  n_err++;
               end
            end
         end
         k++;
      end
      n_cmp++;
      if (n_got != 300) begin
         n_bad++;
         $display("FAIL rand_count: got %0d results, required 300", n_got);
      end
      send_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_back_to_back();
      test_mul();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
